// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide sequencer.
package muldiv_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [2:0] {
    StIdle = 3'd0,
    StMul  = 3'd1,
    StDiv  = 3'd2,
    StFix  = 3'd3,
    StDone = 3'd4
  } muldiv_state_e;

endpackage

// File: rtl/muldiv_addsub.sv
// Shared Width-bit adder/subtractor used by both the shift-add and shift-subtract iterations.
module muldiv_addsub #(
  parameter int unsigned Width = 33
) (
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  input  logic             sub_i,
  output logic [Width-1:0] y_o
);

  always_comb begin
    y_o = sub_i ? (a_i - b_i) : (a_i + b_i);
  end

endmodule

// File: rtl/muldiv_sequencer.sv
// Radix-2 sequential multiply/divide unit for the M extension, one bit per cycle.
// The divide datapath and DIV state are present only when MULDIV_DIV_EN is defined.
module muldiv_sequencer
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  input  logic            flush,
  output logic            stall,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam int unsigned CntW = $clog2(XLEN) + 1;

  muldiv_state_e   state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [2:0]      f3_q, f3_d;
  logic [XLEN-1:0] b_q, b_d;
  logic [XLEN-1:0] hi_q, hi_d;
  logic [XLEN-1:0] lo_q, lo_d;
  logic            neg_q, neg_d;
  logic            neg_rem_q, neg_rem_d;
  logic [XLEN-1:0] result_q, result_d;

  logic            last_iter;
  logic            sign_a, sign_b, sa, sb;
  logic [XLEN-1:0] mag_a, mag_b;
  logic [XLEN:0]   add_a, add_b, add_y;
  logic            add_sub;
  logic [2*XLEN-1:0] prod, prod_fix;
  logic [XLEN-1:0] quo_fix, rem_fix, fix_res;

  assign last_iter = (cnt_q == CntW'(XLEN - 1));

  // Operand signedness: div/rem signed when funct3[0]=0; mulhsu treats only op_a as signed.
  always_comb begin
    sign_a = funct3[2] ? ~funct3[0] : (funct3 != F3_MULHU);
    sign_b = funct3[2] ? ~funct3[0] : ~funct3[1];
    sa     = sign_a & op_a[XLEN-1];
    sb     = sign_b & op_b[XLEN-1];
    mag_a  = sa ? -op_a : op_a;
    mag_b  = sb ? -op_b : op_b;
  end

  // Multiply: {hi,lo} >> 1 after conditionally adding the multiplicand into hi.
  always_comb begin
    add_a   = {1'b0, hi_q};
    add_b   = lo_q[0] ? {1'b0, b_q} : '0;
    add_sub = 1'b0;
`ifdef MULDIV_DIV_EN
    // Divide: trial-subtract the divisor from the partial remainder shifted left.
    if (state_q == StDiv) begin
      add_a   = {hi_q, lo_q[XLEN-1]};
      add_b   = {1'b0, b_q};
      add_sub = 1'b1;
    end
`endif
  end

  muldiv_addsub #(
    .Width(XLEN + 1)
  ) u_addsub (
    .a_i  (add_a),
    .b_i  (add_b),
    .sub_i(add_sub),
    .y_o  (add_y)
  );

  always_comb begin
    prod     = {hi_q, lo_q};
    prod_fix = neg_q ? -prod : prod;
    quo_fix  = neg_q ? -lo_q : lo_q;
    rem_fix  = neg_rem_q ? -hi_q : hi_q;
    if (f3_q[2]) begin
      fix_res = f3_q[1] ? rem_fix : quo_fix;
    end else if (f3_q == F3_MUL) begin
      fix_res = prod_fix[XLEN-1:0];
    end else begin
      fix_res = prod_fix[2*XLEN-1:XLEN];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (start && !flush) begin
`ifdef MULDIV_DIV_EN
          state_d = funct3[2] ? StDiv : StMul;
`else
          state_d = funct3[2] ? StDone : StMul;
`endif
        end
      end
      StMul: begin
        if (last_iter) state_d = StFix;
      end
`ifdef MULDIV_DIV_EN
      StDiv: begin
        if (b_q == '0) begin
          state_d = StDone;
        end else if (last_iter) begin
          state_d = StFix;
        end
      end
`endif
      StFix:   state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (flush) state_d = StIdle;
  end

  always_comb begin
    stall = rst_n & ((start & (state_q == StIdle)) |
                     (state_q == StMul) | (state_q == StDiv) | (state_q == StFix));
    done  = (state_q == StDone) & ~flush;
  end

  assign result = result_q;

  always_comb begin
    f3_d      = f3_q;
    b_d       = b_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    cnt_d     = cnt_q;
    neg_d     = neg_q;
    neg_rem_d = neg_rem_q;
    result_d  = result_q;
    case (state_q)
      StIdle: begin
        if (start && !flush) begin
          f3_d      = funct3;
          b_d       = mag_b;
          // A zero divisor keeps the raw dividend so rem/remu can return it untouched.
          lo_d      = (funct3[2] && (op_b == '0)) ? op_a : mag_a;
          hi_d      = '0;
          cnt_d     = '0;
          neg_d     = sa ^ sb;
          neg_rem_d = sa;
`ifndef MULDIV_DIV_EN
          if (funct3[2]) result_d = '0;
`endif
        end
      end
      StMul: begin
        cnt_d = cnt_q + CntW'(1);
        hi_d  = add_y[XLEN:1];
        lo_d  = {add_y[0], lo_q[XLEN-1:1]};
      end
`ifdef MULDIV_DIV_EN
      StDiv: begin
        if (b_q == '0) begin
          result_d = f3_q[1] ? lo_q : '1;
        end else begin
          cnt_d = cnt_q + CntW'(1);
          if (!add_y[XLEN]) begin
            hi_d = add_y[XLEN-1:0];
            lo_d = {lo_q[XLEN-2:0], 1'b1};
          end else begin
            hi_d = {hi_q[XLEN-2:0], lo_q[XLEN-1]};
            lo_d = {lo_q[XLEN-2:0], 1'b0};
          end
        end
      end
`endif
      StFix:   result_d = fix_res;
      default: ;
    endcase
    if (flush) result_d = result_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      f3_q      <= '0;
      b_q       <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      neg_q     <= 1'b0;
      neg_rem_q <= 1'b0;
      result_q  <= '0;
    end else begin
      cnt_q     <= cnt_d;
      f3_q      <= f3_d;
      b_q       <= b_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      neg_q     <= neg_d;
      neg_rem_q <= neg_rem_d;
      result_q  <= result_d;
    end
  end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed M-extension cases, flush/reset aborts
// and randomized operations against a plain-arithmetic reference model.
module tb_muldiv_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  funct3;
  logic [31:0] op_a;
  logic [31:0] op_b;
  logic        flush;
  logic        stall;
  logic        done;
  logic [31:0] result;

  int checks   = 0;
  int failures = 0;
  logic [31:0] last_res;

  always #5 clk = ~clk;

  muldiv_sequencer #(
    .XLEN(32)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .funct3(funct3),
    .op_a  (op_a),
    .op_b  (op_b),
    .flush (flush),
    .stall (stall),
    .done  (done),
    .result(result)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a,
                                             input logic [31:0] b);
    logic [63:0] ea, eb, p;
    logic [31:0] r;
    ea = {32'b0, a};
    eb = {32'b0, b};
    r  = '0;
    case (f3)
      3'd0: begin p = ea * eb; r = p[31:0]; end
      3'd1: begin
        ea = {{32{a[31]}}, a}; eb = {{32{b[31]}}, b}; p = ea * eb; r = p[63:32];
      end
      3'd2: begin ea = {{32{a[31]}}, a}; p = ea * eb; r = p[63:32]; end
      3'd3: begin p = ea * eb; r = p[63:32]; end
`ifdef MULDIV_DIV_EN
      3'd4: begin
        if (b == 0) r = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
        else r = $signed(a) / $signed(b);
      end
      3'd5: r = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) r = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 0;
        else r = $signed(a) % $signed(b);
      end
      3'd7: r = (b == 0) ? a : a % b;
`endif
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic int ref_latency(input logic [2:0] f3, input logic [31:0] b);
    if (!f3[2]) return 34;
`ifdef MULDIV_DIV_EN
    return (b == 0) ? 2 : 34;
`else
    return (b == b) ? 1 : 1;
`endif
  endfunction

  // Issues one operation; optional poke re-asserts start mid-operation to prove it is ignored.
  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input bit poke);
    logic [31:0] exp;
    int lat;
    int seen;
    exp = ref_result(f3, a, b);
    lat = ref_latency(f3, b);
    @(negedge clk);
    start = 1'b1; funct3 = f3; op_a = a; op_b = b;
    #1 check({tag, ".stall_issue"}, {63'b0, stall}, 64'd1);
    @(posedge clk);
    #1 start = 1'b0; op_a = $urandom; op_b = $urandom; funct3 = 3'($urandom);
    seen = 0;
    for (int c = 1; c <= 60 && seen == 0; c++) begin
      @(negedge clk);
      if (poke && c == 3) start = 1'b1;
      if (poke && c == 4) start = 1'b0;
      if (done) seen = c;
    end
    check({tag, ".latency"}, 64'(seen), 64'(lat));
    check({tag, ".result"}, {32'b0, result}, {32'b0, exp});
    check({tag, ".stall_done"}, {63'b0, stall}, 64'd0);
    @(negedge clk);
    check({tag, ".done_pulse"}, {63'b0, done}, 64'd0);
    last_res = exp;
  endtask

  task automatic count_dones(input string tag, input int cycles);
    int n;
    n = 0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (done) n++;
    end
    check({tag, ".no_done"}, 64'(n), 64'd0);
    check({tag, ".stall_idle"}, {63'b0, stall}, 64'd0);
  endtask

  initial begin
    logic [2:0]  rf3;
    logic [31:0] ra, rb;
    int          sel;

    rst_n = 1'b1; start = 1'b1; flush = 1'b0; funct3 = 3'd0; op_a = '0; op_b = '0;
    last_res = '0;
    #2 rst_n = 1'b0;
    #1;
    check("reset.stall", {63'b0, stall}, 64'd0);
    check("reset.done", {63'b0, done}, 64'd0);
    check("reset.result", {32'b0, result}, 64'd0);
    #20 start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check("idle.stall", {63'b0, stall}, 64'd0);

    run_op("mul_7_m3", 3'd0, 32'd7, 32'hFFFF_FFFD, 1'b0);
    check("mul_7_m3.literal", {32'b0, result}, 64'hFFFF_FFEB);
    run_op("mulhu_max", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op("mulh_m1", 3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    run_op("mulhsu_m1_2", 3'd2, 32'hFFFF_FFFF, 32'd2, 1'b0);
    run_op("mul_poke", 3'd1, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
    run_op("div_m20_6", 3'd4, 32'hFFFF_FFEC, 32'd6, 1'b0);
    run_op("rem_m20_6", 3'd6, 32'hFFFF_FFEC, 32'd6, 1'b0);
    run_op("divu_by0", 3'd5, 32'd123, 32'd0, 1'b0);
    run_op("remu_by0", 3'd7, 32'd123, 32'd0, 1'b0);
    run_op("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
    run_op("mul_seed", 3'd0, 32'd1000, 32'd77, 1'b0);

    // Flush at iteration 10 of a multiply: no done, result untouched.
    @(negedge clk);
    start = 1'b1; funct3 = 3'd0; op_a = 32'd5; op_b = 32'd9;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 10; c++) @(negedge clk);
    check("flush.busy", {63'b0, stall}, 64'd1);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(negedge clk);
    check("flush.stall", {63'b0, stall}, 64'd0);
    check("flush.result", {32'b0, result}, {32'b0, last_res});
    count_dones("flush", 40);
    check("flush.result_after", {32'b0, result}, {32'b0, last_res});

    // start together with flush in IDLE must not launch.
    @(negedge clk);
    start = 1'b1; flush = 1'b1; funct3 = 3'd0; op_a = 32'd3; op_b = 32'd3;
    @(posedge clk);
    #1 start = 1'b0; flush = 1'b0;
    @(negedge clk);
    check("flush_start.stall", {63'b0, stall}, 64'd0);
    count_dones("flush_start", 40);

    // Reset pulse mid-operation discards it.
    @(negedge clk);
    start = 1'b1; op_a = 32'd100; op_b = 32'd7;
`ifdef MULDIV_DIV_EN
    funct3 = 3'd4;
`else
    funct3 = 3'd0;
`endif
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 5; c++) @(negedge clk);
    rst_n = 1'b0; start = 1'b1;
    #1;
    check("rst_mid.stall", {63'b0, stall}, 64'd0);
    check("rst_mid.done", {63'b0, done}, 64'd0);
    check("rst_mid.result", {32'b0, result}, 64'd0);
    @(negedge clk);
    start = 1'b0; rst_n = 1'b1;
    count_dones("rst_mid", 40);
    check("rst_mid.result_after", {32'b0, result}, 64'd0);

    run_op("post_reset", 3'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);

    for (int i = 0; i < 40; i++) begin
      rf3 = 3'($urandom_range(0, 7));
      ra  = $urandom;
      rb  = $urandom;
      sel = $urandom_range(0, 7);
      case (sel)
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 20));
        3: ra = 32'($urandom_range(0, 50));
        default: ;
      endcase
      run_op($sformatf("rand%0d_f%0d", i, rf3), rf3, ra, rb, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_sequencer.md
MULDIV_SEQUENCER -- requirements
Module: muldiv_sequencer

Interface
REQ-001 SHALL have parameter XLEN, default 32, operand/result width; iteration count equals XLEN.
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port start  input  1  issue request; sampled only in IDLE.
REQ-005 SHALL have port funct3  input  3  M-extension op: 000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu.
REQ-006 SHALL have port op_a  input  XLEN  rs1 value (multiplicand/dividend).
REQ-007 SHALL have port op_b  input  XLEN  rs2 value (multiplier/divisor).
REQ-008 SHALL have port flush  input  1  pipeline kill; aborts any operation.
REQ-009 SHALL have port stall  output  1  freeze upstream pipeline stages.
REQ-010 SHALL have port done  output  1  one-cycle result-valid pulse.
REQ-011 SHALL have port result  output  XLEN  operation result.

Function
REQ-012 SHALL implement states IDLE, MUL, DIV, FIX, DONE; encoding from muldiv_pkg.
REQ-013 IDLE: start=1 and flush=0 SHALL latch funct3, op_a, op_b; go to MUL (funct3[2]=0) or DIV (funct3[2]=1).
REQ-014 MUL/DIV SHALL run exactly XLEN radix-2 iterations (shift-add / restoring shift-subtract) on operand magnitudes, counted by a log2(XLEN)+1-bit counter, then go to FIX.
REQ-015 FIX SHALL apply sign correction (negate by rule: mul/mulh both signed, mulhsu op_a signed only, div/rem quotient sign a^b, remainder sign a) and go to DONE.
REQ-016 DONE SHALL assert done for exactly one cycle with result valid, then return to IDLE.
REQ-017 Latency start-cycle to done-cycle SHALL be XLEN+2 cycles (34 at XLEN=32) for normal operations.
REQ-018 mul SHALL return low XLEN bits of product; mulh/mulhsu/mulhu SHALL return high XLEN bits.
REQ-019 Divide by zero SHALL skip iterations (DIV->DONE next cycle): div/divu quotient all ones, rem/remu = op_a; latency 2 cycles.
REQ-020 Signed overflow (op_a = most negative, op_b = -1, div/rem) SHALL follow normal path: quotient = op_a, remainder = 0.
REQ-021 stall SHALL equal (start & state==IDLE) | (state in MUL, DIV, FIX); low in DONE.
REQ-022 start while not IDLE SHALL be ignored; no queueing.
REQ-023 flush in any state SHALL force IDLE next cycle, suppress done, leave result unchanged; flush with start in IDLE SHALL not launch.
REQ-024 result SHALL hold its value from DONE until the next DONE.

Reset
REQ-025 rst_n low SHALL asynchronously force state IDLE, counter 0, operand/accumulator registers 0, result 0, done 0; stall SHALL be 0 while rst_n is low.
REQ-026 Reset asserted mid-operation SHALL discard the operation without a done pulse.

Configuration
REQ-027 Macro MULDIV_DIV_EN SHALL compile in the divide datapath and DIV state.
REQ-028 Without MULDIV_DIV_EN, funct3[2]=1 SHALL go IDLE->DONE directly, result 0, latency 1 cycle; multiply behaviour unchanged.

Structure
REQ-029 Package muldiv_pkg SHALL hold the state enum type, funct3 localparams (F3_MUL..F3_REMU) and the XLEN default constant.
REQ-030 One sub-module muldiv_addsub (XLEN+1-bit add/subtract, shared by multiply and divide iterations) SHALL be instantiated once.

Verification
REQ-031 mul op_a=7, op_b=-3 -> done at cycle 34 after start, result 32'hFFFF_FFEB.
REQ-032 mulhu op_a=op_b=32'hFFFF_FFFF -> result 32'hFFFF_FFFE; mulh same operands -> result 0.
REQ-033 div op_a=-20, op_b=6 -> quotient 32'hFFFF_FFFD; rem same -> 32'hFFFF_FFFE.
REQ-034 divu op_a=123, op_b=0 -> done 2 cycles after start, result 32'hFFFF_FFFF; remu -> 123.
REQ-035 div op_a=32'h8000_0000, op_b=-1 -> result 32'h8000_0000; rem -> 0.
REQ-036 start mul, flush at iteration 10, rst_n pulse during a later div -> no done pulse, state IDLE, stall 0, result unchanged by flush.
